// File: rtl/wb_ram_arbiter_if.sv
// rtl/wb_ram_arbiter_if.sv - flat multi-master and single-slave Wishbone bundle around the RAM arbiter
interface wb_ram_arbiter_if #(
  parameter int MASTERS    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int SEL_WIDTH = DATA_WIDTH / 8;

  // Requester side, master k occupies slice k of every vector
  logic [MASTERS*ADDR_WIDTH-1:0] m_adr_i;
  logic [MASTERS*DATA_WIDTH-1:0] m_dat_i;
  logic [MASTERS*SEL_WIDTH-1:0]  m_sel_i;
  logic [MASTERS-1:0]            m_cyc_i;
  logic [MASTERS-1:0]            m_stb_i;
  logic [MASTERS-1:0]            m_we_i;
  logic [3*MASTERS-1:0]          m_cti_i;
  logic [2*MASTERS-1:0]          m_bte_i;
  logic [MASTERS*DATA_WIDTH-1:0] m_dat_o;
  logic [MASTERS-1:0]            m_ack_o;
  logic [MASTERS-1:0]            m_err_o;
  logic [MASTERS-1:0]            m_rty_o;

  // RAM slave side
  logic [ADDR_WIDTH-1:0]         s_adr_o;
  logic [DATA_WIDTH-1:0]         s_dat_o;
  logic [SEL_WIDTH-1:0]          s_sel_o;
  logic                          s_cyc_o;
  logic                          s_stb_o;
  logic                          s_we_o;
  logic [2:0]                    s_cti_o;
  logic [1:0]                    s_bte_o;
  logic [DATA_WIDTH-1:0]         s_dat_i;
  logic                          s_ack_i;
  logic                          s_err_i;
  logic                          s_rty_i;

  // Arbiter view
  modport slave (
    input  m_adr_i, m_dat_i, m_sel_i, m_cyc_i, m_stb_i, m_we_i, m_cti_i, m_bte_i,
    input  s_dat_i, s_ack_i, s_err_i, s_rty_i,
    output m_dat_o, m_ack_o, m_err_o, m_rty_o,
    output s_adr_o, s_dat_o, s_sel_o, s_cyc_o, s_stb_o, s_we_o, s_cti_o, s_bte_o
  );

  // Environment view: requesters plus the RAM tile port
  modport master (
    output m_adr_i, m_dat_i, m_sel_i, m_cyc_i, m_stb_i, m_we_i, m_cti_i, m_bte_i,
    output s_dat_i, s_ack_i, s_err_i, s_rty_i,
    input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
    input  s_adr_o, s_dat_o, s_sel_o, s_cyc_o, s_stb_o, s_we_o, s_cti_o, s_bte_o
  );
endinterface

// File: rtl/wb_ram_arbiter.sv
// rtl/wb_ram_arbiter.sv - round-robin Wishbone arbiter with per-beat watchdog in front of the RAM tile port
module wb_ram_arbiter #(
  parameter int MASTERS    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic               clk,
  input  logic               rst_sys_n,
  wb_ram_arbiter_if.slave    bus,
  output logic [MASTERS-1:0] grant_o,
  output logic               timeout_o
);
  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_W     = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam int WD_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit WD_EN     = (TIMEOUT > 0);

  typedef enum logic [1:0] {ST_IDLE, ST_OWN, ST_ABORT} state_t;

  state_t             state_q, state_d;
  logic [MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [WD_W-1:0]    wdog_q, wdog_d;

  logic [IDX_W-1:0]   gidx;
  logic [MASTERS-1:0] rot;
  logic [MASTERS-1:0] pick_oh;
  int                 first_i;
  int                 pick_i;
  logic               own_cyc;
  logic               resp;
  logic               expire;

  assign own_cyc   = |(grant_q & bus.m_cyc_i);
  assign resp      = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;
  assign expire    = WD_EN && (state_q == ST_OWN) && own_cyc && bus.s_stb_o && !resp &&
                     (wdog_q == WD_W'(TIMEOUT));
  assign timeout_o = expire;
  assign grant_o   = grant_q;
  assign bus.m_dat_o = {MASTERS{bus.s_dat_i}};

  // Owner index, recorded as the new round-robin pointer when the grant is released
  always_comb begin
    gidx = '0;
    for (int k = 0; k < MASTERS; k++) begin
      if (grant_q[k]) gidx = IDX_W'(k);
    end
  end

  // Rotate requests so the master after last sits at bit 0, then take the lowest set bit
  always_comb begin
    rot     = MASTERS'({bus.m_cyc_i, bus.m_cyc_i} >> (int'(last_q) + 1));
    first_i = 0;
    for (int k = MASTERS - 1; k >= 0; k--) begin
      if (rot[k]) first_i = k;
    end
    pick_i = int'(last_q) + 1 + first_i;
    if (pick_i >= MASTERS) pick_i = pick_i - MASTERS;
    pick_oh = MASTERS'(1) << pick_i;
  end

  // Route the granted master's request to the RAM slave; all zero outside OWN
  always_comb begin
    bus.s_adr_o = '0;
    bus.s_dat_o = '0;
    bus.s_sel_o = '0;
    bus.s_cyc_o = 1'b0;
    bus.s_stb_o = 1'b0;
    bus.s_we_o  = 1'b0;
    bus.s_cti_o = '0;
    bus.s_bte_o = '0;
    if (state_q == ST_OWN) begin
      for (int k = 0; k < MASTERS; k++) begin
        if (grant_q[k]) begin
          bus.s_adr_o = bus.m_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
          bus.s_dat_o = bus.m_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
          bus.s_sel_o = bus.m_sel_i[k*SEL_WIDTH +: SEL_WIDTH];
          bus.s_cyc_o = bus.m_cyc_i[k];
          bus.s_stb_o = bus.m_stb_i[k];
          bus.s_we_o  = bus.m_we_i[k];
          bus.s_cti_o = bus.m_cti_i[k*3 +: 3];
          bus.s_bte_o = bus.m_bte_i[k*2 +: 2];
        end
      end
    end
  end

  // Responses reach only the owner; an aborted owner gets err for every strobe it still holds
  always_comb begin
    bus.m_ack_o = '0;
    bus.m_err_o = '0;
    bus.m_rty_o = '0;
    case (state_q)
      ST_OWN: begin
        bus.m_ack_o = grant_q & {MASTERS{bus.s_ack_i}};
        bus.m_err_o = grant_q & {MASTERS{bus.s_err_i}};
        bus.m_rty_o = grant_q & {MASTERS{bus.s_rty_i}};
      end
      ST_ABORT: bus.m_err_o = grant_q & bus.m_stb_i;
      default: ;
    endcase
  end

  // Grant is held for the whole cyc span; only the watchdog can divert it to ABORT
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (|bus.m_cyc_i) begin
          grant_d = pick_oh;
          state_d = ST_OWN;
        end
      end
      ST_OWN: begin
        if (!own_cyc) begin
          last_d  = gidx;
          grant_d = '0;
          state_d = ST_IDLE;
        end else if (expire) begin
          state_d = ST_ABORT;
        end
      end
      ST_ABORT: begin
        if (!own_cyc) begin
          last_d  = gidx;
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Per-beat stall counter: restarts on any response or idle strobe, saturates at TIMEOUT
  always_comb begin
    wdog_d = '0;
    if (WD_EN && (state_q == ST_OWN) && bus.s_stb_o && !resp) begin
      wdog_d = (wdog_q == WD_W'(TIMEOUT)) ? wdog_q : wdog_q + 1'b1;
    end
  end

  // State registers; reset leaves master 0 as the first winner
  always_ff @(posedge clk or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(MASTERS - 1);
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
    end
  end
endmodule

// File: tb/tb_wb_ram_arbiter.sv
// tb/tb_wb_ram_arbiter.sv - randomized bench for wb_ram_arbiter against a cycle-level reference model
module tb_wb_ram_arbiter;
  localparam int M  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [M-1:0] grant;
  logic         tmo;

  always #5 clk = ~clk;

  wb_ram_arbiter_if #(.MASTERS(M), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  wb_ram_arbiter #(.MASTERS(M), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_sys_n (rst_n),
    .bus       (bus),
    .grant_o   (grant),
    .timeout_o (tmo)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Requester agents: act 0 idle, 1 running a burst, 2 lingering after an error
  int           act[M];
  int           beats[M];
  int           gap[M];
  int           linger[M];
  logic [AW-1:0] adr[M];
  logic [DW-1:0] dat[M];
  logic [SW-1:0] sel[M];
  logic          we[M];
  logic [1:0]    bte[M];
  logic [M-1:0]  en;
  int            gap_max;
  int            force_delay;
  bit            allow_hang;

  // RAM slave behaviour
  int sl_busy, sl_cnt, sl_delay, sl_kind;

  // Reference model: phase 0 idle, 1 owned, 2 aborted; owner, last owner, stall cycles of current beat
  int   st, own, last, wd;
  logic exp_scyc;

  function automatic void model_reset();
    st = 0; own = 0; last = M - 1; wd = 0; sl_busy = 0;
  endfunction

  function automatic void new_txn(input int k);
    act[k]   = 1;
    beats[k] = $urandom_range(1, 4);
    adr[k]   = $urandom & 32'hFFFF_FFFC;
    dat[k]   = $urandom;
    sel[k]   = SW'($urandom);
    we[k]    = 1'($urandom);
    bte[k]   = 2'($urandom);
  endfunction

  task automatic step();
    logic [M-1:0]    cyc, stb, fw, e_ack, e_err, e_rty, e_grant;
    logic [M*AW-1:0] fa;
    logic [M*DW-1:0] fd;
    logic [M*SW-1:0] fs;
    logic [3*M-1:0]  fc;
    logic [2*M-1:0]  fb;
    logic [DW-1:0]   sdat;
    logic [127:0]    e_req;
    logic            sack, serr, srty, e_to, o;
    int              g, r, c;
    @(negedge clk);
    for (int k = 0; k < M; k++) begin
      cyc[k] = (act[k] != 0);
      stb[k] = cyc[k];
      fw[k]  = we[k];
      fa[k*AW +: AW] = adr[k];
      fd[k*DW +: DW] = dat[k];
      fs[k*SW +: SW] = sel[k];
      fc[k*3 +: 3]   = (beats[k] == 1) ? 3'b111 : 3'b010;
      fb[k*2 +: 2]   = bte[k];
    end
    g = own;
    o = (st == 1);
    e_req = '0;
    if (o) e_req = 128'({cyc[g], stb[g], we[g], adr[g], dat[g], sel[g], fc[g*3 +: 3], bte[g]});
    exp_scyc = o && cyc[g];
    sack = 1'b0; serr = 1'b0; srty = 1'b0;
    sdat = $urandom;
    if (o && stb[g]) begin
      if (sl_busy == 0) begin
        sl_busy = 1;
        sl_cnt  = 0;
        r = $urandom_range(0, 15);
        sl_delay = (r < 6) ? 0 : (r < 10) ? 1 : (r < 12) ? 2 : (r == 12) ? 3 :
                   (r == 13) ? TO - 1 : (r == 14) ? TO : (allow_hang ? 1000 : 0);
        sl_kind = $urandom_range(0, 15);
        if (force_delay >= 0) begin
          sl_delay = force_delay;
          sl_kind  = 0;
        end
      end
      if (sl_cnt == sl_delay) begin
        sack = (sl_kind < 14);
        serr = (sl_kind == 14);
        srty = (sl_kind == 15);
        sl_busy = 0;
      end else begin
        sl_cnt++;
      end
    end else begin
      sl_busy = 0;
      r = $urandom_range(0, 7);
      sack = (r == 0); serr = (r == 1); srty = (r == 2);
    end
    bus.m_cyc_i = cyc; bus.m_stb_i = stb; bus.m_we_i = fw;
    bus.m_adr_i = fa;  bus.m_dat_i = fd;  bus.m_sel_i = fs;
    bus.m_cti_i = fc;  bus.m_bte_i = fb;
    bus.s_dat_i = sdat; bus.s_ack_i = sack; bus.s_err_i = serr; bus.s_rty_i = srty;
    e_ack   = (o && sack) ? (M'(1) << g) : '0;
    e_rty   = (o && srty) ? (M'(1) << g) : '0;
    e_err   = ((o && serr) || (st == 2 && stb[g])) ? (M'(1) << g) : '0;
    e_to    = o && cyc[g] && stb[g] && !(sack || serr || srty) && (wd == TO);
    e_grant = (st != 0) ? (M'(1) << g) : '0;
    #1;
    check("grant", 128'(grant), 128'(e_grant));
    check("req", 128'({bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, bus.s_adr_o, bus.s_dat_o,
                       bus.s_sel_o, bus.s_cti_o, bus.s_bte_o}), e_req);
    check("resp", 128'({bus.m_ack_o, bus.m_err_o, bus.m_rty_o, tmo}),
                  128'({e_ack, e_err, e_rty, e_to}));
    check("mdat", 128'(bus.m_dat_o), 128'({M{sdat}}));
    // Advance the model by the arbitration rules
    case (st)
      0: begin
        wd = 0;
        if (|cyc) begin
          c = -1;
          for (int i = 1; i <= M; i++) if (c < 0 && cyc[(last + i) % M]) c = (last + i) % M;
          own = c;
          st  = 1;
        end
      end
      1: begin
        if (!cyc[g]) begin
          last = g; st = 0; wd = 0;
        end else begin
          if (e_to) st = 2;
          wd = (!stb[g] || sack || serr || srty) ? 0 : ((wd < TO) ? wd + 1 : wd);
        end
      end
      default: begin
        wd = 0;
        if (!cyc[g]) begin last = g; st = 0; end
      end
    endcase
    // Advance the requesters using the responses the model says they received
    for (int k = 0; k < M; k++) begin
      if (act[k] == 2) begin
        linger[k]--;
        if (linger[k] <= 0) begin act[k] = 0; gap[k] = $urandom_range(0, gap_max); end
      end else if (act[k] == 1) begin
        if (e_ack[k]) begin
          beats[k]--;
          if (beats[k] == 0) begin
            act[k] = 0; gap[k] = $urandom_range(0, gap_max);
          end else begin
            adr[k] = adr[k] + 32'd4; dat[k] = $urandom;
          end
        end else if (e_err[k]) begin
          linger[k] = $urandom_range(0, 2);
          act[k] = (linger[k] > 0) ? 2 : 0;
          gap[k] = $urandom_range(0, gap_max);
        end
      end else if (en[k]) begin
        if (gap[k] > 0) gap[k]--;
        else new_txn(k);
      end
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    for (int k = 0; k < M; k++) begin
      act[k] = 0; beats[k] = 1; gap[k] = 0; linger[k] = 0;
      adr[k] = '0; dat[k] = '0; sel[k] = '0; we[k] = 1'b0; bte[k] = '0;
    end
    en = '0; gap_max = 0; force_delay = -1; allow_hang = 1'b0;
    bus.m_cyc_i = '1; bus.m_stb_i = '1; bus.m_we_i = '0; bus.m_adr_i = '0; bus.m_dat_i = '0;
    bus.m_sel_i = '0; bus.m_cti_i = '0; bus.m_bte_i = '0;
    bus.s_dat_i = '0; bus.s_ack_i = 1'b1; bus.s_err_i = 1'b0; bus.s_rty_i = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check("rst_grant", 128'(grant), 128'(0));
    check("rst_scyc", 128'(bus.s_cyc_o), 128'(0));
    check("rst_ack", 128'(bus.m_ack_o), 128'(0));
    check("rst_tmo", 128'(tmo), 128'(0));
    bus.m_cyc_i = '0; bus.m_stb_i = '0; bus.s_ack_i = 1'b0;
    rst_n = 1'b1;

    // Single master write to 0x10, slave acks at once
    en = 4'b0001; force_delay = 0;
    new_txn(0);
    adr[0] = 32'h10; dat[0] = 32'hDEAD_BEEF; we[0] = 1'b1; beats[0] = 1;
    step();
    step();
    check("single_adr", 128'(bus.s_adr_o), 128'(32'h10));
    check("single_ack", 128'(bus.m_ack_o), 128'(4'b0001));
    repeat (4) step();

    // All masters requesting back to back: strict rotation
    en = '1; gap_max = 0;
    repeat (80) step();

    // Random traffic with stalls, expiry races, errors, retries and hung beats
    force_delay = -1; allow_hang = 1'b1; gap_max = 4;
    repeat (4000) step();

    // Asynchronous reset in the middle of an owned cycle with an ack pending
    n = 0;
    while (!exp_scyc && n < 200) begin step(); n++; end
    check("busy_wait", 128'(exp_scyc), 128'(1));
    bus.s_ack_i = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_scyc", 128'(bus.s_cyc_o), 128'(0));
    check("arst_grant", 128'(grant), 128'(0));
    check("arst_ack", 128'(bus.m_ack_o), 128'(0));
    repeat (2) @(negedge clk);
    bus.m_cyc_i = '0; bus.m_stb_i = '0; bus.s_ack_i = 1'b0;
    model_reset();
    allow_hang = 1'b0; force_delay = 0; gap_max = 2;
    for (int k = 0; k < M; k++) begin
      new_txn(k); linger[k] = 0;
    end
    rst_n = 1'b1;
    step();
    step();
    check("first_prio", 128'(grant), 128'(4'b0001));
    force_delay = -1;
    repeat (100) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
